// File: rtl/regfile_scan_ctrl_pkg.sv
// Shared definitions for the regfile scan controller: the scan FSM state
// encoding and the default regfile geometry used by processor and regfile.
package regfile_scan_ctrl_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALT    = 3'd1,
    READ    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } scan_state_e;

endpackage

// File: rtl/regfile_scan_ctrl.sv
// Debug scan controller. It halts the processor, borrows regfile read port A,
// streams registers FIRST_REG..NUM_REGS-1 out on a valid/ready interface and
// then hands the port back.
//
// Optional build macro SCAN_TIMEOUT_EN: abort the scan with scan_err=1 if
// halt_ack does not arrive within ACK_TIMEOUT cycles of HALT. Without it the
// controller waits in HALT forever and scan_err is constant 0.
//
// Dump stream handshake: dump_reg/dump_data are offered while dump_valid=1 and
// hold steady until a rising edge sees dump_valid && dump_ready; that edge is
// the single transfer of the word. dump_valid never drops without a transfer
// (except on reset).
import regfile_scan_ctrl_pkg::*;

module regfile_scan_ctrl #(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIRST_REG   = 0,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              halt_req,
  input  logic              halt_ack,
  input  logic [ADDR_W-1:0] proc_readRegA,
  output logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [DATA_W-1:0] data_readRegA,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_reg,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              scan_err,
  output scan_state_e       dbg_state
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] dump_reg_q, dump_reg_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

`ifdef SCAN_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            scan_err_q, scan_err_d;
`endif

  // State, index and captured dump word; reset drops the scan at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_IDX;
      dump_reg_q  <= '0;
      dump_data_q <= '0;
`ifdef SCAN_TIMEOUT_EN
      to_cnt_q    <= '0;
      scan_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_reg_q  <= dump_reg_d;
      dump_data_q <= dump_data_d;
`ifdef SCAN_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      scan_err_q  <= scan_err_d;
`endif
    end
  end

  // Next-state logic, port-A mux and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dump_reg_d    = dump_reg_q;
    dump_data_d   = dump_data_q;
`ifdef SCAN_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    scan_err_d    = scan_err_q;
`endif
    ctrl_readRegA = proc_readRegA;
    halt_req      = 1'b0;
    busy          = 1'b0;
    dump_valid    = 1'b0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HALT;
          idx_d      = FIRST_IDX;
`ifdef SCAN_TIMEOUT_EN
          to_cnt_d   = '0;
          scan_err_d = 1'b0;
`endif
        end
      end
      HALT: begin
        halt_req = 1'b1;
        busy     = 1'b1;
        if (halt_ack) begin
          state_d = READ;
        end
`ifdef SCAN_TIMEOUT_EN
        // The cycle that sees the ACK_TIMEOUT-th unacknowledged HALT cycle aborts.
        else if (to_cnt_q >= TO_W'(ACK_TIMEOUT - 1)) begin
          state_d    = DONE;
          scan_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      READ: begin
        halt_req      = 1'b1;
        busy          = 1'b1;
        ctrl_readRegA = idx_q;
        dump_reg_d    = idx_q;
        dump_data_d   = data_readRegA;
        state_d       = PRESENT;
      end
      PRESENT: begin
        halt_req      = 1'b1;
        busy          = 1'b1;
        dump_valid    = 1'b1;
        ctrl_readRegA = idx_q;
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dump_reg  = dump_reg_q;
  assign dump_data = dump_data_q;
  assign dbg_state = state_q;

`ifdef SCAN_TIMEOUT_EN
  assign scan_err = scan_err_q;
`else
  assign scan_err = 1'b0;
`endif

endmodule
